audio_i2s_capture: RTL and testbench

- Upstream capture stage for the audio_jack AXI4-Lite peripheral.
- Receives a slave-mode I2S stream from the line-in codec ADC (SCLK/LRCK driven by the codec) and oversamples it in the AXI clock domain.
- Deserializes each left/right frame into signed samples and buffers stereo frames in a first-word-fall-through FIFO.
- The register block pops frames from the FIFO and reports FIFO level and overflow to software.

---
 rtl/audio_jack_pkg.sv | 17 +
 rtl/audio_frame_fifo.sv | 71 +++++++
 rtl/audio_i2s_capture.sv | 170 +++++++++++++++++
 tb/tb_audio_i2s_capture.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_jack_pkg.sv
// rtl/audio_jack_pkg.sv - shared types for the audio_jack I2S capture path
package audio_jack_pkg;

  localparam int DEFAULT_SAMPLE_WIDTH = 24;

  typedef struct packed {
    logic [DEFAULT_SAMPLE_WIDTH-1:0] left;
    logic [DEFAULT_SAMPLE_WIDTH-1:0] right;
  } stereo_frame_t;

  typedef enum logic [1:0] {
    ALIGN = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } capture_state_e;

endpackage

// File: rtl/audio_frame_fifo.sv
// rtl/audio_frame_fifo.sv - first-word-fall-through circular FIFO of stereo frames
module audio_frame_fifo
  import audio_jack_pkg::*;
#(
  parameter type frame_t   = stereo_frame_t,
  parameter int  DEPTH     = 16,
  parameter int  LVL_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 clr_ovf,
  input  logic                 push,
  input  frame_t               push_data,
  input  logic                 pop,
  output logic                 rd_valid,
  output frame_t               rd_data,
  output logic [LVL_WIDTH-1:0] level,
  output logic                 overflow,
  output logic                 push_strobe
);

  localparam int AW = $clog2(DEPTH);

  frame_t               mem [DEPTH];
  logic [LVL_WIDTH-1:0] wptr;
  logic [LVL_WIDTH-1:0] rptr;
  logic                 full;
  logic                 do_pop;
  logic                 do_push;
  logic                 drop;

  // Pointers carry one extra bit so full and empty stay distinguishable.
  assign level    = wptr - rptr;
  assign rd_valid = (level != '0);
  assign full     = (level == LVL_WIDTH'(DEPTH));
  assign do_pop   = pop && rd_valid;
  assign do_push  = push && !flush && (!full || do_pop);
  assign drop     = push && !flush && full && !do_pop;
  assign rd_data  = rd_valid ? mem[rptr[AW-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr        <= '0;
      rptr        <= '0;
      overflow    <= 1'b0;
      push_strobe <= 1'b0;
    end else begin
      push_strobe <= do_push;
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (do_push) wptr <= wptr + 1'b1;
        if (do_pop)  rptr <= rptr + 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/audio_i2s_capture.sv
// rtl/audio_i2s_capture.sv - oversampled slave I2S receiver feeding a stereo frame FIFO
module audio_i2s_capture
  import audio_jack_pkg::*;
#(
  parameter int SAMPLE_WIDTH = DEFAULT_SAMPLE_WIDTH,
  parameter int FIFO_DEPTH   = 16,
  parameter int LVL_WIDTH    = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    enable,
  input  logic                    flush,
  input  logic                    clr_ovf,
  input  logic                    i2s_sclk,
  input  logic                    i2s_lrck,
  input  logic                    i2s_sdin,
  input  logic                    rd_en,
  output logic                    rd_valid,
  output logic [SAMPLE_WIDTH-1:0] rd_left,
  output logic [SAMPLE_WIDTH-1:0] rd_right,
  output logic [LVL_WIDTH-1:0]    fifo_level,
  output logic                    overflow,
  output logic                    frame_strobe
);

  localparam int CW = $clog2(SAMPLE_WIDTH + 1);

  typedef struct packed {
    logic [SAMPLE_WIDTH-1:0] left;
    logic [SAMPLE_WIDTH-1:0] right;
  } frame_t;

  // [0],[1] synchronize; [2] is the history stage used for edge detection.
  logic [2:0] sclk_q;
  logic [2:0] lrck_q;
  logic [2:0] sdin_q;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      sclk_q <= '0;
      lrck_q <= '0;
      sdin_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], i2s_sclk};
      lrck_q <= {lrck_q[1:0], i2s_lrck};
      sdin_q <= {sdin_q[1:0], i2s_sdin};
    end
  end

  // lrck/sdin are taken from the history stage: the value just before the SCLK rise.
  logic sclk_rise;
  logic lrck;
  logic sdin;
  logic lrck_prev;
  logic lrck_fall;
  logic lrck_rise;

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign lrck      = lrck_q[2];
  assign sdin      = sdin_q[2];
  assign lrck_fall = lrck_prev & ~lrck;
  assign lrck_rise = ~lrck_prev & lrck;

  capture_state_e          state, state_nxt;
  logic [SAMPLE_WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]           bitcnt, bitcnt_nxt;
  logic [SAMPLE_WIDTH-1:0] left_hold, left_hold_nxt;
  logic [SAMPLE_WIDTH-1:0] shift_data;
  logic [CW-1:0]           shift_cnt;
  logic [SAMPLE_WIDTH-1:0] word;
  logic                    push;
  frame_t                  push_frame;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state     <= ALIGN;
      lrck_prev <= 1'b0;
      shreg     <= '0;
      bitcnt    <= '0;
      left_hold <= '0;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      bitcnt    <= bitcnt_nxt;
      left_hold <= left_hold_nxt;
      if (sclk_rise) lrck_prev <= lrck;
    end
  end

  always_comb begin
    state_nxt     = state;
    shreg_nxt     = shreg;
    bitcnt_nxt    = bitcnt;
    left_hold_nxt = left_hold;
    push          = 1'b0;
    push_frame    = '0;
    shift_data    = shreg;
    shift_cnt     = bitcnt;
    // The bit on the edge-detecting rise is still the LSB of the word that just ended.
    if (bitcnt < CW'(SAMPLE_WIDTH)) begin
      shift_data = {shreg[SAMPLE_WIDTH-2:0], sdin};
      shift_cnt  = bitcnt + 1'b1;
    end
    word = shift_data << (CW'(SAMPLE_WIDTH) - shift_cnt);

    if (!enable) begin
      state_nxt = ALIGN;
    end else if (sclk_rise) begin
      case (state)
        ALIGN: begin
          if (lrck_fall) begin
            state_nxt  = LEFT;
            shreg_nxt  = '0;
            bitcnt_nxt = '0;
          end
        end
        LEFT: begin
          if (lrck_rise) begin
            state_nxt     = RIGHT;
            left_hold_nxt = word;
            shreg_nxt     = '0;
            bitcnt_nxt    = '0;
          end else begin
            shreg_nxt  = shift_data;
            bitcnt_nxt = shift_cnt;
          end
        end
        RIGHT: begin
          if (lrck_fall) begin
            state_nxt        = LEFT;
            push             = 1'b1;
            push_frame.left  = left_hold;
            push_frame.right = word;
            shreg_nxt        = '0;
            bitcnt_nxt       = '0;
          end else begin
            shreg_nxt  = shift_data;
            bitcnt_nxt = shift_cnt;
          end
        end
        default: state_nxt = ALIGN;
      endcase
    end
  end

  frame_t head;

  audio_frame_fifo #(
    .frame_t   (frame_t),
    .DEPTH     (FIFO_DEPTH),
    .LVL_WIDTH (LVL_WIDTH)
  ) u_fifo (
    .clk         (ACLK),
    .rst_n       (ARESETN),
    .flush       (flush),
    .clr_ovf     (clr_ovf),
    .push        (push),
    .push_data   (push_frame),
    .pop         (rd_en),
    .rd_valid    (rd_valid),
    .rd_data     (head),
    .level       (fifo_level),
    .overflow    (overflow),
    .push_strobe (frame_strobe)
  );

  assign rd_left  = head.left;
  assign rd_right = head.right;

endmodule

// File: tb/tb_audio_i2s_capture.sv
// tb/tb_audio_i2s_capture.sv - scoreboard bench for audio_i2s_capture
module tb_audio_i2s_capture;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        enable, flush, clr_ovf;
  logic        i2s_sclk, i2s_lrck, i2s_sdin;
  logic        rd_en;
  logic        rd_valid;
  logic [23:0] rd_left, rd_right;
  logic [4:0]  fifo_level;
  logic        overflow, frame_strobe;

  audio_i2s_capture dut (
    .ACLK         (ACLK),
    .ARESETN      (ARESETN),
    .enable       (enable),
    .flush        (flush),
    .clr_ovf      (clr_ovf),
    .i2s_sclk     (i2s_sclk),
    .i2s_lrck     (i2s_lrck),
    .i2s_sdin     (i2s_sdin),
    .rd_en        (rd_en),
    .rd_valid     (rd_valid),
    .rd_left      (rd_left),
    .rd_right     (rd_right),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .frame_strobe (frame_strobe)
  );

  always #5 ACLK = ~ACLK;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          strobe_cnt = 0;
  int          cyc = 0;
  int          pop_req_cycle = -1;
  int          pop_mode = 0;
  int          half = 160;
  logic        prev_bit = 1'b0;
  logic [47:0] exp_q[$];

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  // Pop driver: 0 none, 1 always, 2 random, plus one-shot timed pops.
  initial begin
    rd_en = 1'b0;
    forever begin
      @(posedge ACLK);
      cyc++;
      #1;
      rd_en = (pop_mode == 1) || (pop_mode == 2 && $urandom_range(0, 1) == 1) ||
              (cyc == pop_req_cycle);
    end
  end

  // Scoreboard monitor: every accepted pop is compared with the oldest expected frame.
  initial begin
    forever begin
      @(negedge ACLK);
      if (frame_strobe) strobe_cnt++;
      if (ARESETN && rd_en && rd_valid) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL pop_unexpected: got %h required no frame", {rd_left, rd_right});
        end else begin
          chk("pop_frame", {rd_left, rd_right}, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Data leaves one SCLK after LRCK changes, as in I2S.
  task automatic sclk_cycle(input logic lr, input logic b);
    i2s_sclk = 1'b0;
    i2s_lrck = lr;
    i2s_sdin = prev_bit;
    prev_bit = b;
    #half;
    i2s_sclk = 1'b1;
    #half;
  endtask

  task automatic send_slot(input logic lr, input logic [31:0] d, input int n);
    for (int i = n - 1; i >= 0; i--) sclk_cycle(lr, d[i]);
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n);
    send_slot(1'b0, l, n);
    send_slot(1'b1, r, n);
  endtask

  task automatic tail(input bit with_pop);
    i2s_sclk = 1'b0;
    i2s_lrck = 1'b0;
    i2s_sdin = prev_bit;
    prev_bit = 1'b0;
    #half;
    i2s_sclk = 1'b1;
    if (with_pop) pop_req_cycle = cyc + 2;
    #half;
  endtask

  task automatic settle();
    repeat (4) @(posedge ACLK);
    #2;
  endtask

  task automatic idle();
    settle();
    enable = 1'b0;
    repeat (4) sclk_cycle(1'b1, 1'b0);
    enable = 1'b1;
    sclk_cycle(1'b1, 1'b0);
  endtask

  task automatic drain(input int n);
    pop_mode = 1;
    repeat (n) @(posedge ACLK);
    #2;
    pop_mode = 0;
    settle();
  endtask

  initial begin
    int s0;
    logic [23:0] a;
    ARESETN  = 1'b0;
    enable   = 1'b1;
    flush    = 1'b0;
    clr_ovf  = 1'b0;
    i2s_sclk = 1'b0;
    i2s_lrck = 1'b1;
    i2s_sdin = 1'b0;

    #100;
    chk("rst_valid", 48'(rd_valid), 48'd0);
    chk("rst_level", 48'(fifo_level), 48'd0);
    chk("rst_ovf", 48'(overflow), 48'd0);
    chk("rst_strobe", 48'(frame_strobe), 48'd0);
    chk("rst_head", {rd_left, rd_right}, 48'd0);
    #100;
    @(posedge ACLK);
    #2;
    ARESETN = 1'b1;

    // Alignment from the middle of a right word at ~3 MHz SCLK
    send_slot(1'b1, 32'h2AA, 10);
    exp_q.push_back({24'h123456, 24'hABCDEF});
    send_frame(32'h123456, 32'hABCDEF, 24);
    tail(1'b0);
    settle();
    chk("align_valid", 48'(rd_valid), 48'd1);
    chk("align_head", {rd_left, rd_right}, {24'h123456, 24'hABCDEF});
    chk("align_level", 48'(fifo_level), 48'd1);
    chk("align_strobes", 48'(strobe_cnt), 48'd1);
    drain(5);
    chk("align_drained", 48'(fifo_level), 48'd0);

    // Word length: 32-bit slots truncate, 16-bit slots zero-fill
    half = 50;
    idle();
    pop_mode = 1;
    exp_q.push_back({24'h800001, 24'h7FFFFF});
    exp_q.push_back({24'h800100, 24'h123400});
    send_frame(32'h800001FF, 32'h7FFFFF00, 32);
    send_frame(32'h00008001, 32'h00001234, 16);
    tail(1'b0);
    settle();
    pop_mode = 0;
    settle();
    chk("wordlen_sb_empty", 48'(exp_q.size()), 48'd0);
    chk("wordlen_strobes", 48'(strobe_cnt), 48'd3);

    // Fill to 16 and overflow on frame 16
    idle();
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back({24'(i), ~24'(i)});
      send_frame({8'h0, 24'(i)}, {8'h0, ~24'(i)}, 24);
    end
    tail(1'b0);
    settle();
    chk("fill_level", 48'(fifo_level), 48'd16);
    chk("fill_ovf", 48'(overflow), 48'd1);
    chk("fill_head", {rd_left, rd_right}, {24'h000000, 24'hFFFFFF});
    chk("fill_strobes", 48'(strobe_cnt), 48'd19);
    clr_ovf = 1'b1;
    @(posedge ACLK);
    #2;
    clr_ovf = 1'b0;
    chk("clr_ovf", 48'(overflow), 48'd0);

    // Push and pop together while full
    idle();
    exp_q.push_back({24'h111111, 24'h222222});
    send_frame(32'h111111, 32'h222222, 24);
    tail(1'b1);
    settle();
    chk("full_pp_level", 48'(fifo_level), 48'd16);
    chk("full_pp_ovf", 48'(overflow), 48'd0);
    chk("full_pp_head", {rd_left, rd_right}, {24'h000001, 24'hFFFFFE});
    chk("full_pp_strobes", 48'(strobe_cnt), 48'd20);
    drain(40);
    chk("full_drained", 48'(fifo_level), 48'd0);
    chk("full_sb_empty", 48'(exp_q.size()), 48'd0);

    // Flush at level 5
    idle();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({24'h0A0000 + 24'(i), 24'h0B0000 + 24'(i)});
      send_frame(32'h0A0000 + i, 32'h0B0000 + i, 24);
    end
    tail(1'b0);
    settle();
    chk("flush_pre_level", 48'(fifo_level), 48'd5);
    flush = 1'b1;
    @(posedge ACLK);
    #2;
    flush = 1'b0;
    exp_q.delete();
    chk("flush_level", 48'(fifo_level), 48'd0);
    chk("flush_valid", 48'(rd_valid), 48'd0);

    // Enable dropped mid-left-word: only the next fully aligned frame lands
    idle();
    s0 = strobe_cnt;
    a = 24'h5A5A5A;
    for (int i = 23; i >= 12; i--) sclk_cycle(1'b0, a[i]);
    enable = 1'b0;
    sclk_cycle(1'b0, a[11]);
    sclk_cycle(1'b0, a[10]);
    enable = 1'b1;
    for (int i = 9; i >= 0; i--) sclk_cycle(1'b0, a[i]);
    send_slot(1'b1, 32'hA5A5A5, 24);
    exp_q.push_back({24'h0C0C0C, 24'h0D0D0D});
    send_frame(32'h0C0C0C, 32'h0D0D0D, 24);
    tail(1'b0);
    settle();
    chk("enable_strobes", 48'(strobe_cnt - s0), 48'd1);
    chk("enable_level", 48'(fifo_level), 48'd1);
    drain(5);
    chk("enable_sb_empty", 48'(exp_q.size()), 48'd0);

    // Wrap-around with random pops
    idle();
    pop_mode = 2;
    for (int i = 0; i < 40; i++) begin
      exp_q.push_back({24'h000300 + 24'(i), 24'hF00000 + 24'(i)});
      send_frame(32'h000300 + i, 32'hF00000 + i, 24);
    end
    tail(1'b0);
    settle();
    pop_mode = 1;
    repeat (20) @(posedge ACLK);
    #2;
    pop_mode = 0;
    settle();
    chk("wrap_sb_empty", 48'(exp_q.size()), 48'd0);
    chk("wrap_level", 48'(fifo_level), 48'd0);
    chk("wrap_ovf", 48'(overflow), 48'd0);
    chk("wrap_strobes", 48'(strobe_cnt - s0), 48'd41);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
